// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit and the ALU decode tables.
// Holds the operation and FSM-state encodings plus operand helper functions.
// No ports; purely declarations imported by the muldiv RTL.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

  // Widest operand abs_w can handle; the unit's WIDTH must not exceed it.
  localparam int unsigned MD_MAX_W = 64;

  // Two's-complement magnitude of the low w bits of v (upper bits cleared).
  // The most negative value maps onto itself, which reads correctly as unsigned.
  function automatic logic [MD_MAX_W-1:0] abs_w(input logic [MD_MAX_W-1:0] v,
                                                 input int unsigned         w);
    logic [MD_MAX_W-1:0] mask;
    logic [MD_MAX_W-1:0] neg;
    logic                sgn;
    mask = (w >= MD_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
    sgn  = |(v & (64'd1 << (w - 1)));
    neg  = ~v + 64'd1;
    return (sgn ? neg : v) & mask;
  endfunction

  function automatic logic is_signed_op(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_div_op(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter_unit_div_step.sv
// div_step: one restoring radix-2 division step on a packed {rem,quo} register.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Ports: remquo_i {rem,quo} in, divisor_i divisor, remquo_o {rem,quo} after one step.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] remquo_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic [2*WIDTH-1:0] remquo_o
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  // Since rem < divisor on entry, rem_sh < 2*divisor, so a (WIDTH+1)-bit
  // difference never overflows and its MSB is a clean "negative" flag.
  always_comb begin
    rem_sh  = remquo_i[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, divisor_i};
    rem_nxt = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nxt = {remquo_i[WIDTH-2:0], ~diff[WIDTH]};
    remquo_o = {rem_nxt, quo_nxt};
  end

endmodule

// File: rtl/muldiv_iter_unit.sv
// muldiv_iter_unit: multi-cycle MULT/MULTU/DIV/DIVU engine producing the {HI,LO} write value.
// Latency: start in cycle 0 -> done_o in cycle WIDTH+2 (cycle 3 for single-step multiply).
// Backpressure: start_i taken only in IDLE/DONE; stall_o holds the pipe; cancel_i aborts.
// Ports: clk, resetn (async low); start_i/op_i/srca_i/srcb_i request; cancel_i flush;
//        busy_o (CALC/FIX), done_o (1-cycle pulse), res_o {HI,LO}, stall_o to hazard unit.
module muldiv_iter_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_ITER = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  md_op_t             op_i,
  input  logic [WIDTH-1:0]   srca_i,
  input  logic [WIDTH-1:0]   srcb_i,
  input  logic               cancel_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] res_o,
  output logic               stall_o
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  md_state_t       state_q, state_d;
  md_op_t          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // sign_quo: quotient/product must be negated; sign_rem: remainder follows dividend.
  logic            sign_quo_q, sign_quo_d;
  logic            sign_rem_q, sign_rem_d;
  // acc holds {hi,lo} for multiply and {rem,quo} for divide.
  logic [W2-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]   res_q, res_d;

  logic            start_ok;
  logic            signed_in;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]  mul_sum;
  logic [W2-1:0]   mul_next;
  logic [W2-1:0]   mul_full;
  logic [W2-1:0]   div_next;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;
  logic [W2-1:0]   fix_res;

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .remquo_i (acc_q),
    .divisor_i(b_q),
    .remquo_o (div_next)
  );

  // Operand conditioning and datapath steps.
  always_comb begin
    signed_in = is_signed_op(op_i);
    a_abs     = WIDTH'(abs_w(MD_MAX_W'(srca_i), WIDTH));
    b_abs     = WIDTH'(abs_w(MD_MAX_W'(srcb_i), WIDTH));

    // Shift-add: the multiplier sits in the low half and is consumed LSB first
    // while partial sums enter at the top and shift down with it.
    mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    mul_full = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    fix_hi = acc_q[W2-1:WIDTH];
    fix_lo = acc_q[WIDTH-1:0];
    if (is_div_op(op_q)) begin
      if (sign_rem_q) fix_hi = -acc_q[W2-1:WIDTH];
      if (sign_quo_q) fix_lo = -acc_q[WIDTH-1:0];
      fix_res = {fix_hi, fix_lo};
    end else begin
      fix_res = sign_quo_q ? -acc_q : acc_q;
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    res_d      = res_q;

    start_ok = start_i && !cancel_i && ((state_q == MD_IDLE) || (state_q == MD_DONE));

    case (state_q)
      MD_IDLE, MD_DONE: begin
        if (start_ok) begin
          op_d       = op_i;
          a_d        = signed_in ? a_abs : srca_i;
          b_d        = signed_in ? b_abs : srcb_i;
          sign_quo_d = signed_in & (srca_i[WIDTH-1] ^ srcb_i[WIDTH-1]);
          sign_rem_d = signed_in & srca_i[WIDTH-1];
          // Divide starts with rem=0, quo=dividend; multiply with hi=0, lo=multiplier.
          acc_d      = is_div_op(op_i) ? {{WIDTH{1'b0}}, a_d} : {{WIDTH{1'b0}}, b_d};
          cnt_d      = (!is_div_op(op_i) && (MUL_ITER == 0)) ? CW'(1) : CW'(WIDTH);
          state_d    = MD_CALC;
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_CALC: begin
        if (is_div_op(op_q)) begin
          acc_d = div_next;
        end else if (MUL_ITER == 0) begin
          acc_d = mul_full;
        end else begin
          acc_d = mul_next;
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = MD_FIX;
      end
      MD_FIX: begin
        res_d   = fix_res;
        state_d = MD_DONE;
      end
      default: state_d = MD_IDLE;
    endcase

    // Flush beats everything: drop the op and keep the last published result.
    if (cancel_i) begin
      state_d = MD_IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= MD_IDLE;
      op_q       <= MD_MULT;
      a_q        <= '0;
      b_q        <= '0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
    end
  end

  assign busy_o  = (state_q == MD_CALC) || (state_q == MD_FIX);
  assign done_o  = (state_q == MD_DONE);
  assign res_o   = res_q;
  assign stall_o = (start_i | busy_o) & ~done_o & ~cancel_i;

endmodule
